ads_int2float: RTL and testbench

Converts one 24-bit two's-complement ADS1292 channel sample into an IEEE-754 single-precision float. It sits between the ADS1292 SPI sample unpacker and the float-domain filter chain, and feeds the high-pass filter's `i_X_DATA`/`i_X_DATA_VALID`/`o_X_DATA_READY` handshake directly. The conversion is exact: every 24-bit code fits the 24-bit significand, so no rounding logic exists. Normalisation is a serial one-bit-per-cycle shifter, so the block stays small.

---
 rtl/ads_int2float_if.sv | 30 +++
 rtl/ads_int2float.sv | 108 ++++++++++
 tb/tb_ads_int2float.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ads_int2float_if.sv
// Sample-in / float-out handshake bundle for ads_int2float.
// slave = converter side, master = upstream unpacker plus downstream HPF side.
interface ads_int2float_if #(
  parameter int IN_W = 24
);
  logic [IN_W-1:0] i_X_DATA;
  logic            i_X_DATA_VALID;
  logic            o_X_DATA_READY;
  logic [31:0]     o_Y_DATA;
  logic            o_Y_DATA_VALID;
  logic            i_Y_ACK;

  modport slave (
    input  i_X_DATA,
    input  i_X_DATA_VALID,
    input  i_Y_ACK,
    output o_X_DATA_READY,
    output o_Y_DATA,
    output o_Y_DATA_VALID
  );

  modport master (
    output i_X_DATA,
    output i_X_DATA_VALID,
    output i_Y_ACK,
    input  o_X_DATA_READY,
    input  o_Y_DATA,
    input  o_Y_DATA_VALID
  );
endinterface

// File: rtl/ads_int2float.sv
// Exact 24-bit two's-complement to IEEE-754 single converter, serial normaliser.
// Optional ADS_INT2FLOAT_NORM_EN scales the result by 2^-23 (full scale -> +/-1.0).
module ads_int2float #(
  parameter int EXP_BIAS = 127,
  parameter int IN_W     = 24
) (
  input  logic           i_CLK,
  input  logic           i_RST,
  ads_int2float_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ABS    = 3'd1,
    ST_NORM   = 3'd2,
    ST_PACK   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

`ifdef ADS_INT2FLOAT_NORM_EN
  localparam logic [7:0] EXP_INIT = 8'(EXP_BIAS);
`else
  localparam logic [7:0] EXP_INIT = 8'(EXP_BIAS + IN_W - 1);
`endif

  state_t          state;
  logic            r_sign;
  logic [IN_W-1:0] r_mag;
  logic [7:0]      r_exp;
  logic            r_ready;
  logic [31:0]     r_y;
  logic            r_y_vld;

  // -2^23 negates to 0x800000, which is already the correct unsigned magnitude.
  function automatic logic [IN_W-1:0] f_abs(input logic signed [IN_W-1:0] x);
    logic [IN_W-1:0] u;
    u = $unsigned(x);
    return x[IN_W-1] ? (~u + 1'b1) : u;
  endfunction

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state   <= ST_IDLE;
      r_ready <= 1'b1;
      r_y     <= '0;
      r_y_vld <= 1'b0;
      r_mag   <= '0;
      r_exp   <= '0;
      r_sign  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          r_y_vld <= 1'b0;
          r_ready <= 1'b1;
          if (bus.i_X_DATA_VALID && r_ready) begin
            // raw code parks in r_mag until ST_ABS rewrites it in place
            r_mag   <= bus.i_X_DATA;
            r_ready <= 1'b0;
            state   <= ST_ABS;
          end
        end
        ST_ABS: begin
          r_sign <= r_mag[IN_W-1];
          r_mag  <= f_abs($signed(r_mag));
          r_exp  <= EXP_INIT;
          if (r_mag == '0) begin
            r_y   <= '0;
            state <= ST_FINISH;
          end else begin
            state <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (r_mag[IN_W-1]) begin
            state <= ST_PACK;
          end else begin
            r_mag <= {r_mag[IN_W-2:0], 1'b0};
            r_exp <= r_exp - 8'd1;
          end
        end
        ST_PACK: begin
          r_y     <= {r_sign, r_exp, r_mag[IN_W-2:0]};
          r_y_vld <= 1'b1;
          state   <= ST_FINISH;
        end
        ST_FINISH: begin
          // zero path arrives with valid low; it rises here one cycle later
          if (r_y_vld && bus.i_Y_ACK) begin
            r_y_vld <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            r_y_vld <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          r_ready <= 1'b1;
          r_y_vld <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_X_DATA_READY = r_ready;
  assign bus.o_Y_DATA       = r_y;
  assign bus.o_Y_DATA_VALID = r_y_vld;

endmodule

// File: tb/tb_ads_int2float.sv
// Randomised self-checking bench for ads_int2float against a real-arithmetic reference.
// Honours ADS_INT2FLOAT_NORM_EN the same way as the design.
module tb_ads_int2float;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  ads_int2float_if #(.IN_W(24)) bus();

  ads_int2float #(.EXP_BIAS(127), .IN_W(24)) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: let the simulator's double arithmetic do the conversion, then repack.
  function automatic logic [31:0] ref_float(input logic [23:0] code);
    int          v;
    real         r;
    logic [63:0] b;
    int          e;
    v = int'($signed(code));
    if (v == 0) return 32'h0;
    r = real'(v);
`ifdef ADS_INT2FLOAT_NORM_EN
    r = r / 8388608.0;
`endif
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], 8'(e), b[51:29]};
  endfunction

  function automatic int ref_lat(input logic [23:0] code);
    int          v;
    logic [63:0] b;
    v = int'($signed(code));
    if (v == 0) return 2;
    if (v < 0) v = -v;
    b = $realtobits(real'(v));
    return 26 - (int'(b[62:52]) - 1023);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample, measure latency, hold ack off for ack_wait cycles, then ack.
  task automatic run_sample(input logic [23:0] x, input int ack_wait, input bit poke,
                            input string tag);
    int          t;
    int          lat;
    logic [31:0] y;
    t = 0;
    while (!bus.o_X_DATA_READY && t < 100) begin
      tick();
      t++;
    end
    check({tag, "_rdy_wait"}, 32'(bus.o_X_DATA_READY), 32'd1);
    bus.i_X_DATA       = x;
    bus.i_X_DATA_VALID = 1'b1;
    tick();
    bus.i_X_DATA_VALID = 1'b0;
    lat = 0;
    while (!bus.o_Y_DATA_VALID && lat < 60) begin
      tick();
      lat++;
    end
    y = bus.o_Y_DATA;
    check({tag, "_data"}, y, ref_float(x));
    check({tag, "_lat"}, 32'(lat), 32'(ref_lat(x)));
    for (int i = 0; i < ack_wait; i++) begin
      if (poke && i == 3) begin
        bus.i_X_DATA       = 24'h123456;
        bus.i_X_DATA_VALID = 1'b1;
      end
      tick();
      bus.i_X_DATA_VALID = 1'b0;
      if (poke) begin
        check({tag, "_hold_vld"}, 32'(bus.o_Y_DATA_VALID), 32'd1);
        check({tag, "_hold_data"}, bus.o_Y_DATA, y);
        check({tag, "_hold_rdy"}, 32'(bus.o_X_DATA_READY), 32'd0);
      end
    end
    bus.i_Y_ACK = 1'b1;
    tick();
    bus.i_Y_ACK = 1'b0;
    check({tag, "_vld_drop"}, 32'(bus.o_Y_DATA_VALID), 32'd0);
    check({tag, "_rdy_low"}, 32'(bus.o_X_DATA_READY), 32'd0);
    tick();
    check({tag, "_rdy_back"}, 32'(bus.o_X_DATA_READY), 32'd1);
    check({tag, "_no_vld"}, 32'(bus.o_Y_DATA_VALID), 32'd0);
  endtask

  initial begin
    int          cnt;
    logic [23:0] code;
    logic [31:0] exp_one, exp_min;
    bus.i_X_DATA       = '0;
    bus.i_X_DATA_VALID = 1'b0;
    bus.i_Y_ACK        = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_rdy", 32'(bus.o_X_DATA_READY), 32'd1);
    check("rst_vld", 32'(bus.o_Y_DATA_VALID), 32'd0);
    check("rst_data", bus.o_Y_DATA, 32'h0);

`ifdef ADS_INT2FLOAT_NORM_EN
    exp_one = 32'h34000000;
    exp_min = 32'hBF800000;
`else
    exp_one = 32'h3F800000;
    exp_min = 32'hCB000000;
`endif
    check("ref_one", ref_float(24'h000001), exp_one);
    check("ref_min", ref_float(24'h800000), exp_min);

    run_sample(24'h000001, 0, 1'b0, "one");
    run_sample(24'hFFFFFF, 1, 1'b0, "neg1");
    run_sample(24'h7FFFFF, 0, 1'b0, "maxpos");
    run_sample(24'h800000, 2, 1'b0, "minneg");
    run_sample(24'h000000, 0, 1'b0, "zero");
    run_sample(24'h000400, 10, 1'b1, "hold");

    // reset while the serial shifter is mid-way through 0x000010
    bus.i_X_DATA       = 24'h000010;
    bus.i_X_DATA_VALID = 1'b1;
    tick();
    bus.i_X_DATA_VALID = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_rdy", 32'(bus.o_X_DATA_READY), 32'd1);
    check("midrst_vld", 32'(bus.o_Y_DATA_VALID), 32'd0);
    check("midrst_data", bus.o_Y_DATA, 32'h0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.o_Y_DATA_VALID) cnt++;
    end
    check("midrst_silent", 32'(cnt), 32'd0);
    run_sample(24'h000002, 0, 1'b0, "after_rst");

    for (int i = 0; i < 100; i++) begin
      code = 24'($urandom);
      case ($urandom_range(0, 9))
        0: code = 24'h000000;
        1: code = 24'h800000;
        2: code = code >> $urandom_range(1, 23);
        default: ;
      endcase
      run_sample(code, int'($urandom_range(0, 3)), 1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
